// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, shared-tick debounce, press/release pulses.
// Define BTN_DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat FSMs.
module btn_debounce_multi #(
   parameter int N_BTN         = 4,
   parameter int CLK_HZ        = 100_000_000,
   parameter int TICK_HZ       = 100_000,
   parameter int STABLE_CNT    = 8,
   parameter int REPEAT_DELAY  = 50_000,
   parameter int REPEAT_PERIOD = 10_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release,
   output logic [N_BTN-1:0] o_repeat
);

   localparam int DIV    = CLK_HZ / TICK_HZ;
   localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam bit CFG_OK = (N_BTN >= 1) && (DIV >= 2) && (STABLE_CNT >= 1) &&
                           (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   if (!CFG_OK) begin : g_cfg_check
      $error("btn_debounce_multi: illegal parameter combination");
   end

   logic [TICK_W-1:0] tick_cnt_q;
   logic [TICK_W-1:0] tick_cnt_d;
   logic              tick;

   always_comb begin
      tick       = (tick_cnt_q == TICK_W'(DIV - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
      end
   end

   // Acceptance strobes, valid only on a tick; shared with the repeat FSMs.
   logic [N_BTN-1:0] accept_rise;
   logic [N_BTN-1:0] accept_fall;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             level_q;
      logic             level_d;
      logic             press_q;
      logic             release_q;
      logic             accept;

      always_comb begin
         cnt_d   = cnt_q;
         level_d = level_q;
         accept  = 1'b0;
         if (tick) begin
            if (sync2_q[gi] == level_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
               accept  = 1'b1;
               level_d = sync2_q[gi];
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      assign accept_rise[gi] = accept &  sync2_q[gi];
      assign accept_fall[gi] = accept & ~sync2_q[gi];

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= accept_rise[gi];
            release_q <= accept_fall[gi];
         end
      end

      assign o_level[gi]   = level_q;
      assign o_press[gi]   = press_q;
      assign o_release[gi] = release_q;
   end

`ifdef BTN_DEBOUNCE_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   typedef enum logic [1:0] {
      RPT_IDLE = 2'd0,
      RPT_HOLD = 2'd1,
      RPT_RUN  = 2'd2
   } rpt_state_e;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_rpt
      rpt_state_e        state_q;
      logic [HOLD_W-1:0] hold_cnt_q;
      logic              repeat_q;

      // A release accepted on a tick wins over a repeat due on that same tick.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q    <= RPT_IDLE;
            hold_cnt_q <= '0;
            repeat_q   <= 1'b0;
         end else begin
            repeat_q <= 1'b0;
            case (state_q)
               RPT_IDLE: begin
                  if (accept_rise[gi]) begin
                     state_q    <= RPT_HOLD;
                     hold_cnt_q <= '0;
                  end
               end
               RPT_HOLD: begin
                  if (accept_fall[gi]) begin
                     state_q    <= RPT_IDLE;
                     hold_cnt_q <= '0;
                  end else if (tick) begin
                     if (hold_cnt_q == HOLD_W'(REPEAT_DELAY - 1)) begin
                        repeat_q   <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= RPT_RUN;
                     end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                     end
                  end
               end
               RPT_RUN: begin
                  if (accept_fall[gi]) begin
                     state_q    <= RPT_IDLE;
                     hold_cnt_q <= '0;
                  end else if (tick) begin
                     if (hold_cnt_q == HOLD_W'(REPEAT_PERIOD - 1)) begin
                        repeat_q   <= 1'b1;
                        hold_cnt_q <= '0;
                     end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                     end
                  end
               end
               default: begin
                  state_q    <= RPT_IDLE;
                  hold_cnt_q <= '0;
               end
            endcase
         end
      end

      assign o_repeat[gi] = repeat_q;
   end
`else
   assign o_repeat = '0;
`endif

endmodule
